regfile_wb_scheduler: RTL and testbench
=======================================

// Module: regfile_wb_scheduler
// PURPOSE
//  Write-back scheduler for the 2-write-port integer register file of the 2-way superscalar core.
//  Merges three write-back requesters into regfile ports 1/2: ALU lane0 (older), ALU lane1 (younger), LSU load return (oldest).
//  Resolves same-cycle WAW, suppresses x0 writes, bounds LSU starvation. Registered outputs drive Wen1/2, Rd_addr1/2, write_data1/2.
// PARAMETERS
//  XLEN          64  data width of write-back values
//  STARVE_LIMIT  4   consecutive LSU stall cycles before forced LSU grant (>=1)
//  PERF_W        16  width of performance counters (WB_PERF_EN only)
// PORTS
//  clk          in   1     clock, all state on rising edge
//  reset        in   1     asynchronous, active-high reset
//  l0_valid     in   1     lane0 write-back request
//  l0_rd        in   5     lane0 destination register
//  l0_data      in   XLEN  lane0 write-back value
//  l0_ready     out  1     lane0 accepted (valid&&ready)
//  l1_valid     in   1     lane1 write-back request
//  l1_rd        in   5     lane1 destination register
//  l1_data      in   XLEN  lane1 write-back value
//  l1_ready     out  1     lane1 accepted
//  lsu_valid    in   1     load-return write-back request
//  lsu_rd       in   5     load destination register
//  lsu_data     in   XLEN  load value
//  lsu_ready    out  1     load accepted
//  wen1/wen2    out  1     regfile write enables, ports 1/2 (registered)
//  rd_addr1/2   out  5     regfile write addresses (registered)
//  wdata1/2     out  XLEN  regfile write data (registered)
// BEHAVIOUR
//  - Reset: wen1/2=0, rd_addr1/2=0, wdata1/2=0, all readies 0, FSM=NORMAL, stall_cnt=0. Reset mid-operation discards registered writes.
//  - Latency: an accepted request appears on wen/rd_addr/wdata exactly 1 cycle later, for exactly 1 cycle; wen=0 otherwise.
//  - Readies are combinational from valids and state; l0_ready=1 whenever out of reset.
//  - A request "needs a port" iff valid && rd!=0. Valid requests with rd==0 are accepted (ready=1) and never written.
//  - NORMAL: l1_ready=1. LSU accepted iff lane0 and lane1 not both needing ports.
//  - Port mapping: lane0->port1, lane1->port2; LSU takes port1 if lane0 needs none, else port2.
//  - stall_cnt: +1 each cycle lsu_valid&&!lsu_ready (saturates); cleared on LSU accept or !lsu_valid.
//  - NORMAL->FORCE when a stall occurs with stall_cnt==STARVE_LIMIT-1.
//  - FORCE: if lane0 and lane1 both need ports and lsu_valid, l1_ready=0 and LSU takes port2; LSU always accepted.
//    FORCE->NORMAL on LSU accept or lsu_valid==0; stall_cnt cleared.
//  - WAW in one cycle: age LSU < lane0 < lane1; among accepted port-needing requests with equal rd only the youngest
//    asserts wen; older ones are accepted but their wen=0 (port left idle).
//  - Never wen1&&wen2 with rd_addr1==rd_addr2; never wen with rd_addr==0.
// CONFIGURATION
//  WB_PERF_EN defined: adds outputs perf_lsu_stall[PERF_W-1:0] (cycles lsu_valid&&!lsu_ready) and
//    perf_waw_drop[PERF_W-1:0] (accepted writes suppressed by WAW); both saturate, reset to 0.
//  WB_PERF_EN undefined: ports and counters absent; scheduling identical.
// TESTING
//  1. l0(rd=5,0x11), l1(rd=6,0x22), no LSU -> next cycle wen1=1 rd1=5 wd1=0x11, wen2=1 rd2=6 wd2=0x22.
//  2. l0(rd=0), lsu(rd=9,0xAB) -> both ready; next cycle wen1=1 rd1=9 wd1=0xAB, wen2=0.
//  3. l0(rd=7,0x1), l1(rd=7,0x2) -> both ready; next cycle wen1=0, wen2=1 rd2=7 wd2=0x2 (perf_waw_drop=1).
//  4. l0,l1 need ports every cycle, lsu(rd=3) held, STARVE_LIMIT=4 -> lsu_ready=0 cycles 0-3; cycle 4 l1_ready=0,
//     lsu_ready=1; cycle 5 wen2=1 rd2=3; FSM back to NORMAL.
//  5. lsu(rd=4,0x5) with l0(rd=4,0x6) only -> LSU on port2 suppressed; next cycle wen1=1 rd1=4 wd1=0x6, wen2=0.
//  6. reset asserted in cycle after accept -> wen1/wen2 drop to 0 immediately, FSM NORMAL, counters 0.

Source files
------------

// File: rtl/regfile_wb_scheduler_if.sv
// Write-back request/response bundle between the three requesters
// and the 2-port regfile scheduler.
interface regfile_wb_scheduler_if #(
  parameter int XLEN = 64
);
  logic            l0_valid;
  logic [4:0]      l0_rd;
  logic [XLEN-1:0] l0_data;
  logic            l0_ready;
  logic            l1_valid;
  logic [4:0]      l1_rd;
  logic [XLEN-1:0] l1_data;
  logic            l1_ready;
  logic            lsu_valid;
  logic [4:0]      lsu_rd;
  logic [XLEN-1:0] lsu_data;
  logic            lsu_ready;
  logic            wen1;
  logic            wen2;
  logic [4:0]      rd_addr1;
  logic [4:0]      rd_addr2;
  logic [XLEN-1:0] wdata1;
  logic [XLEN-1:0] wdata2;

  modport master (
    output l0_valid, l0_rd, l0_data,
    output l1_valid, l1_rd, l1_data,
    output lsu_valid, lsu_rd, lsu_data,
    input  l0_ready, l1_ready, lsu_ready,
    input  wen1, wen2, rd_addr1, rd_addr2,
    input  wdata1, wdata2
  );

  modport slave (
    input  l0_valid, l0_rd, l0_data,
    input  l1_valid, l1_rd, l1_data,
    input  lsu_valid, lsu_rd, lsu_data,
    output l0_ready, l1_ready, lsu_ready,
    output wen1, wen2, rd_addr1, rd_addr2,
    output wdata1, wdata2
  );
endinterface

// File: rtl/regfile_wb_scheduler.sv
// Write-back scheduler: merges lane0/lane1/LSU onto 2 regfile ports.
// Define WB_PERF_EN to add LSU-stall and WAW-drop counters.
module regfile_wb_scheduler #(
  parameter int XLEN         = 64,
  parameter int STARVE_LIMIT = 4,
  parameter int PERF_W       = 16
) (
  input  logic clk,
  input  logic reset,
  regfile_wb_scheduler_if.slave wb
`ifdef WB_PERF_EN
  ,
  output logic [PERF_W-1:0] perf_lsu_stall,
  output logic [PERF_W-1:0] perf_waw_drop
`endif
);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] LIM    = SW'(STARVE_LIMIT);
  localparam logic [SW-1:0] LIM_M1 = SW'(STARVE_LIMIT - 1);

  if (STARVE_LIMIT < 1 || PERF_W < 1) begin : g_chk
    $error("bad regfile_wb_scheduler parameters");
  end

  typedef enum logic {NORMAL, FORCE} st_e;

  st_e           state_q, state_d;
  logic [SW-1:0] stall_q, stall_d;

  logic n0, n1, nl;
  logic l0_rdy, l1_rdy, lsu_rdy;
  logic stall, lacc;
  logic a1, al, w0, wl, drop;

  logic            wen1_q, wen1_d, wen2_q, wen2_d;
  logic [4:0]      rd1_q, rd1_d, rd2_q, rd2_d;
  logic [XLEN-1:0] wd1_q, wd1_d, wd2_q, wd2_d;

  assign n0 = wb.l0_valid && (wb.l0_rd != 5'd0);
  assign n1 = wb.l1_valid && (wb.l1_rd != 5'd0);
  assign nl = wb.lsu_valid && (wb.lsu_rd != 5'd0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= NORMAL;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      stall_q <= stall_d;
    end
  end

  always_comb begin
    state_d = state_q;
    stall_d = '0;
    if (stall)
      stall_d = (stall_q == LIM) ? stall_q : stall_q + 1'b1;
    unique case (state_q)
      NORMAL: if (stall && stall_q == LIM_M1) state_d = FORCE;
      FORCE:  if (lacc || !wb.lsu_valid) state_d = NORMAL;
      default: state_d = NORMAL;
    endcase
  end

  // In FORCE the LSU steals lane1's port only when all three contend
  always_comb begin
    l0_rdy  = 1'b0;
    l1_rdy  = 1'b0;
    lsu_rdy = 1'b0;
    if (!reset) begin
      l0_rdy = 1'b1;
      unique case (state_q)
        NORMAL: begin
          l1_rdy  = 1'b1;
          lsu_rdy = !(n0 && n1);
        end
        FORCE: begin
          l1_rdy  = !(n0 && n1 && wb.lsu_valid);
          lsu_rdy = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign wb.l0_ready  = l0_rdy;
  assign wb.l1_ready  = l1_rdy;
  assign wb.lsu_ready = lsu_rdy;

  assign stall = wb.lsu_valid && !lsu_rdy;
  assign lacc  = wb.lsu_valid && lsu_rdy;

  // WAW: age order LSU < lane0 < lane1, youngest same-rd writer wins
  assign a1 = n1 && l1_rdy;
  assign al = nl && lsu_rdy;
  assign w0 = n0 && !(a1 && wb.l0_rd == wb.l1_rd);
  assign wl = al && !(n0 && wb.lsu_rd == wb.l0_rd)
                 && !(a1 && wb.lsu_rd == wb.l1_rd);
  assign drop = (n0 && !w0) || (al && !wl);

  always_comb begin
    wen1_d = w0 || (wl && !n0);
    rd1_d  = w0 ? wb.l0_rd : wb.lsu_rd;
    wd1_d  = w0 ? wb.l0_data : wb.lsu_data;
    wen2_d = a1 || (wl && n0);
    rd2_d  = a1 ? wb.l1_rd : wb.lsu_rd;
    wd2_d  = a1 ? wb.l1_data : wb.lsu_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wen1_q <= 1'b0;
      wen2_q <= 1'b0;
      rd1_q  <= '0;
      rd2_q  <= '0;
      wd1_q  <= '0;
      wd2_q  <= '0;
    end else begin
      wen1_q <= wen1_d;
      wen2_q <= wen2_d;
      if (wen1_d) begin
        rd1_q <= rd1_d;
        wd1_q <= wd1_d;
      end
      if (wen2_d) begin
        rd2_q <= rd2_d;
        wd2_q <= wd2_d;
      end
    end
  end

  assign wb.wen1     = wen1_q;
  assign wb.wen2     = wen2_q;
  assign wb.rd_addr1 = rd1_q;
  assign wb.rd_addr2 = rd2_q;
  assign wb.wdata1   = wd1_q;
  assign wb.wdata2   = wd2_q;

`ifdef WB_PERF_EN
  logic [PERF_W-1:0] pstall_q, pwaw_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pstall_q <= '0;
      pwaw_q   <= '0;
    end else begin
      if (stall && pstall_q != '1) pstall_q <= pstall_q + 1'b1;
      if (drop && pwaw_q != '1) pwaw_q <= pwaw_q + 1'b1;
    end
  end

  assign perf_lsu_stall = pstall_q;
  assign perf_waw_drop  = pwaw_q;
`else
  logic unused_drop;
  assign unused_drop = drop;
`endif
endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Scoreboard bench for regfile_wb_scheduler: driver queues expected
// write-back beats, monitor pops and compares them one cycle later.
module tb_regfile_wb_scheduler;
  typedef struct packed {
    logic v; logic [4:0] rd; logic [63:0] d;
  } req_t;
  typedef struct packed {
    logic w1; logic [4:0] a1; logic [63:0] d1;
    logic w2; logic [4:0] a2; logic [63:0] d2;
  } exp_t;

  localparam req_t NONE = '0;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  regfile_wb_scheduler_if #(.XLEN(64)) wb();
`ifdef WB_PERF_EN
  logic [15:0] perf_lsu_stall, perf_waw_drop;
`endif

  regfile_wb_scheduler #(
    .XLEN(64), .STARVE_LIMIT(4), .PERF_W(16)
  ) dut (
    .clk(clk),
    .reset(reset),
    .wb(wb)
`ifdef WB_PERF_EN
    ,
    .perf_lsu_stall(perf_lsu_stall),
    .perf_waw_drop(perf_waw_drop)
`endif
  );

  int n_vec = 0;
  int n_bad = 0;
  exp_t  sb[$];
  string nq[$];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] want);
    n_vec++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, want);
    end
  endtask

  function automatic req_t rq(input logic v, input logic [4:0] rd,
                              input logic [63:0] d);
    return '{v: v, rd: rd, d: d};
  endfunction

  function automatic exp_t mk(input logic w1, input logic [4:0] a1,
                              input logic [63:0] d1, input logic w2,
                              input logic [4:0] a2,
                              input logic [63:0] d2);
    return '{w1: w1, a1: a1, d1: d1, w2: w2, a2: a2, d2: d2};
  endfunction

  task automatic put(input req_t a, input req_t b, input req_t c);
    wb.l0_valid  = a.v; wb.l0_rd  = a.rd; wb.l0_data  = a.d;
    wb.l1_valid  = b.v; wb.l1_rd  = b.rd; wb.l1_data  = b.d;
    wb.lsu_valid = c.v; wb.lsu_rd = c.rd; wb.lsu_data = c.d;
  endtask

  // rdy = {l0_ready, l1_ready, lsu_ready} expected this cycle
  task automatic drive(input string nm, input req_t a, input req_t b,
                       input req_t c, input logic [2:0] rdy,
                       input exp_t e);
    @(negedge clk);
    put(a, b, c);
    #1;
    chk({nm, ".rdy"}, {61'd0, wb.l0_ready, wb.l1_ready, wb.lsu_ready},
        {61'd0, rdy});
    sb.push_back(e);
    nq.push_back(nm);
  endtask

  task automatic starve(input string nm);
    for (int i = 0; i < 4; i++)
      drive($sformatf("%s%0d", nm, i), rq(1, 1, 64'(i)),
            rq(1, 2, 64'h100 + 64'(i)), rq(1, 3, 64'h33), 3'b110,
            mk(1, 1, 64'(i), 1, 2, 64'h100 + 64'(i)));
    drive({nm, "4"}, rq(1, 1, 64'h50), rq(1, 2, 64'h51),
          rq(1, 3, 64'h33), 3'b101, mk(1, 1, 64'h50, 1, 3, 64'h33));
    drive({nm, "5"}, rq(1, 1, 64'h60), rq(1, 2, 64'h61), NONE,
          3'b110, mk(1, 1, 64'h60, 1, 2, 64'h61));
  endtask

  always begin : monitor
    exp_t  e;
    string nm;
    @(posedge clk);
    #1;
    if (sb.size() > 0) begin
      e  = sb.pop_front();
      nm = nq.pop_front();
      chk({nm, ".wen1"}, {63'd0, wb.wen1}, {63'd0, e.w1});
      chk({nm, ".wen2"}, {63'd0, wb.wen2}, {63'd0, e.w2});
      if (e.w1) begin
        chk({nm, ".rd1"}, {59'd0, wb.rd_addr1}, {59'd0, e.a1});
        chk({nm, ".wd1"}, wb.wdata1, e.d1);
      end
      if (e.w2) begin
        chk({nm, ".rd2"}, {59'd0, wb.rd_addr2}, {59'd0, e.a2});
        chk({nm, ".wd2"}, wb.wdata2, e.d2);
      end
    end else if (wb.wen1 || wb.wen2) begin
      chk("spurious_wen", {62'd0, wb.wen1, wb.wen2}, 64'd0);
    end
  end

  initial begin
    put(NONE, NONE, NONE);
    #3;
    chk("rst.wen", {62'd0, wb.wen1, wb.wen2}, 64'd0);
    chk("rst.addr", {54'd0, wb.rd_addr1, wb.rd_addr2}, 64'd0);
    chk("rst.wd1", wb.wdata1, 64'd0);
    chk("rst.wd2", wb.wdata2, 64'd0);
    chk("rst.rdy", {61'd0, wb.l0_ready, wb.l1_ready, wb.lsu_ready},
        64'd0);
    @(negedge clk);
    reset = 1'b0;

    drive("t1", rq(1, 5, 64'h11), rq(1, 6, 64'h22), NONE, 3'b110,
          mk(1, 5, 64'h11, 1, 6, 64'h22));
    drive("t2", rq(1, 0, 64'h99), NONE, rq(1, 9, 64'hAB), 3'b111,
          mk(1, 9, 64'hAB, 0, 0, 0));
    drive("t3", rq(1, 7, 64'h1), rq(1, 7, 64'h2), NONE, 3'b110,
          mk(0, 0, 0, 1, 7, 64'h2));
    drive("t5", rq(1, 4, 64'h6), NONE, rq(1, 4, 64'h5), 3'b111,
          mk(1, 4, 64'h6, 0, 0, 0));
    drive("l1x0", NONE, rq(1, 0, 64'h77), rq(1, 8, 64'h88), 3'b111,
          mk(1, 8, 64'h88, 0, 0, 0));
    drive("lsu_l1", NONE, rq(1, 12, 64'hC), rq(1, 13, 64'hD), 3'b111,
          mk(1, 13, 64'hD, 1, 12, 64'hC));
    drive("waw_l1", NONE, rq(1, 9, 64'h1), rq(1, 9, 64'h2), 3'b111,
          mk(0, 0, 0, 1, 9, 64'h1));
    drive("idle", NONE, NONE, NONE, 3'b111, mk(0, 0, 0, 0, 0, 0));
    starve("t4_");
`ifdef WB_PERF_EN
    @(negedge clk);
    put(NONE, NONE, NONE);
    @(negedge clk);
    chk("perf_stall", 64'(perf_lsu_stall), 64'd4);
    chk("perf_waw", 64'(perf_waw_drop), 64'd3);
`endif

    // build up a partial stall count, then reset right after a write
    drive("pre0", rq(1, 1, 64'h1), rq(1, 2, 64'h2), rq(1, 3, 64'h3),
          3'b110, mk(1, 1, 64'h1, 1, 2, 64'h2));
    drive("pre1", rq(1, 1, 64'h3), rq(1, 2, 64'h4), rq(1, 3, 64'h3),
          3'b110, mk(1, 1, 64'h3, 1, 2, 64'h4));
    drive("t6", rq(1, 5, 64'h55), rq(1, 6, 64'h66), rq(1, 3, 64'h3),
          3'b110, mk(1, 5, 64'h55, 1, 6, 64'h66));
    @(negedge clk);
    put(NONE, NONE, NONE);
    reset = 1'b1;
    #1;
    chk("t6.wen", {62'd0, wb.wen1, wb.wen2}, 64'd0);
    chk("t6.rdy", {61'd0, wb.l0_ready, wb.l1_ready, wb.lsu_ready},
        64'd0);
`ifdef WB_PERF_EN
    chk("t6.perf", {32'(perf_lsu_stall), 32'(perf_waw_drop)}, 64'd0);
`endif
    @(negedge clk);
    reset = 1'b0;
    starve("t6s_");

    @(negedge clk);
    put(NONE, NONE, NONE);
    repeat (3) @(posedge clk);
    #2;
    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
